// File: rtl/div_sequencer.sv
// Radix-2 restoring DIV/DIVU unit: one quotient bit per cycle, ready at WIDTH+1 cycles after start (2 for divide-by-zero).
// No backpressure: stall holds the pipeline while busy, ready pulses once with {remainder, quotient}.
module div_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_div,
  input  logic               annul,
  input  logic [WIDTH-1:0]   opdata1,
  input  logic [WIDTH-1:0]   opdata2,
  output logic [2*WIDTH-1:0] result,
  output logic               ready,
  output logic               stall
);

  typedef enum logic [1:0] {IDLE, DIVZERO, ON, END} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   dvsr_q, dvsr_d;
  logic               neg_quo_q, neg_quo_d;
  logic               neg_rem_q, neg_rem_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               ready_q, ready_d;

  logic               accept;
  logic [WIDTH:0]     shifted;
  logic [WIDTH+1:0]   diff;
  logic               fits;
  logic [WIDTH-1:0]   dvd_mag, dvs_mag;
  logic [WIDTH-1:0]   rem_fix, quo_fix;

  assign accept  = (state_q == IDLE) && start && !annul;
  assign dvd_mag = (signed_div && opdata1[WIDTH-1]) ? -opdata1 : opdata1;
  assign dvs_mag = (signed_div && opdata2[WIDTH-1]) ? -opdata2 : opdata2;

  // Trial subtraction on the shifted partial remainder; a zero top pair means
  // the difference is non-negative and already fits the remainder register.
  assign shifted = {rem_q, quo_q[WIDTH-1]};
  assign diff    = {1'b0, shifted} - {2'b00, dvsr_q};
  assign fits    = (diff[WIDTH+1:WIDTH] == 2'b00);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvsr_d    = dvsr_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;
    ready_d   = 1'b0;
    rem_fix   = '0;
    quo_fix   = '0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          cnt_d = '0;
          if (opdata2 == '0) begin
            // Divide-by-zero returns the raw dividend with no sign fix-up.
            state_d   = DIVZERO;
            rem_d     = opdata1;
            quo_d     = '1;
            dvsr_d    = '0;
            neg_quo_d = 1'b0;
            neg_rem_d = 1'b0;
          end else begin
            state_d   = ON;
            rem_d     = '0;
            quo_d     = dvd_mag;
            dvsr_d    = dvs_mag;
            neg_quo_d = signed_div && (opdata1[WIDTH-1] ^ opdata2[WIDTH-1]);
            neg_rem_d = signed_div && opdata1[WIDTH-1];
          end
        end
      end
      ON: begin
        if (annul) begin
          state_d = IDLE;
        end else begin
          rem_d = fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], fits};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH-1)) state_d = END;
        end
      end
      DIVZERO: state_d = annul ? IDLE : END;
      default: state_d = IDLE;
    endcase

    // Result is captured on the edge into END so it is valid with ready.
    if (state_d == END) begin
      rem_fix  = neg_rem_d ? -rem_d : rem_d;
      quo_fix  = neg_quo_d ? -quo_d : quo_d;
      result_d = {rem_fix, quo_fix};
      ready_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvsr_q    <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvsr_q    <= dvsr_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
    end
  end

  assign result = result_q;
  assign ready  = ready_q;
  // The request cycle stalls combinationally so the pipeline holds the operands.
  assign stall  = rst && (accept || (state_q == ON) || (state_q == DIVZERO));

endmodule
